seq_detector_mealy_param: RTL and testbench
===========================================

Name: seq_detector_mealy_param

Overview:
Parametrised Mealy serial-pattern detector. It compares a qualified serial bit stream against a runtime-loadable pattern of SEQ_LEN bits. It asserts det combinationally in the same cycle as the final matching bit, with selectable overlapping or non-overlapping detection. It also keeps a saturating match counter. It replaces the fixed 2-state detector in the FSM library for protocol framing and sync-word detection.

Parameters:
SEQ_LEN, 4, pattern length in bits; legal range 2..16.
DEFAULT_PAT, 4'b1011, pattern held after reset; SEQ_LEN bits wide.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  qualifies in_bit; the bit is consumed only when high.
in_bit  input  1  serial data bit.
pattern  input  SEQ_LEN  new pattern. pattern[SEQ_LEN-1] is the first bit received and pattern[0] is the last.
pattern_load  input  1  load pattern into pat_reg on the next edge.
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
det  output  1  Mealy match flag; combinational from the current inputs and state.
match_count  output  CNT_W  number of detections, saturating.
state  output  2  FSM state: 0 IDLE, 1 FILL, 2 ARMED.

Behaviour:
- Reset (asynchronous, immediate):
  - pat_reg = DEFAULT_PAT.
  - hist = 0 (SEQ_LEN-1 bits).
  - fill = 0.
  - match_count = 0.
  - state = IDLE.
  - det = 0 while rst is high.
- Registers:
  - hist holds the last SEQ_LEN-1 accepted bits, newest in hist[0].
  - fill counts accepted bits and saturates at SEQ_LEN-1.
- FSM:
  - IDLE: fill == 0.
  - FILL: 0 < fill < SEQ_LEN-1.
  - ARMED: fill == SEQ_LEN-1.
  - state is a registered encoding derived from fill.
- det = in_valid & ~pattern_load & ~rst & (state == ARMED) & ({hist, in_bit} == pat_reg).
  - Zero-cycle latency: det is valid in the same cycle as the last pattern bit.
- Clock edge with pattern_load = 1 (highest priority):
  - pat_reg <= pattern.
  - hist <= 0, fill <= 0, state <= IDLE.
  - in_bit is discarded even if in_valid is high.
  - match_count is unchanged.
- Clock edge with in_valid = 1, no load, and det = 1:
  - match_count increments, holding at 2^CNT_W-1.
  - overlap_en = 1: hist <= {hist, in_bit} truncated to SEQ_LEN-1 bits; fill stays SEQ_LEN-1 (ARMED).
  - overlap_en = 0: hist <= 0, fill <= 0, state <= IDLE. The matching bits are not reused.
- Clock edge with in_valid = 1, no load, and det = 0:
  - hist shifts in in_bit.
  - fill <= min(fill+1, SEQ_LEN-1).
  - state follows fill.
- Clock edge with in_valid = 0: all state holds; det = 0.
- overlap_en is sampled only at the edge where det is high; changing it at other times has no effect.
- Mismatch in ARMED: no state rewind. The shift history inherently provides correct overlap detection (window compare, not prefix FSM).
- Reset asserted mid-stream: partial history is lost; after release, a full SEQ_LEN bits are required before the next det.
- SEQ_LEN = 2: FILL is skipped, so IDLE goes directly to ARMED after one accepted bit.

Test Plan:
1. Reset, then default pattern 1011 with overlap_en=1. Stream 1,0,1,1,0,1,1 -> det high on bit 4 and bit 7 only; match_count = 2.
2. Same stream with overlap_en=0 -> det high on bit 4 only; after bit 7, match_count = 1 and state = ARMED.
3. Stream 1,0,1,1 with in_valid low for 3 cycles between bits 2 and 3 (in_bit toggling during the gap) -> det high on bit 4 only; state holds during the gaps.
4. Load pattern 0110 after bits 1,0,1, with in_valid=1 and in_bit=1 on the load cycle -> that bit is discarded and state = IDLE. Next stream 0,1,1,0 -> det on its 4th bit; match_count increments.
5. CNT_W=2 build, overlap_en=1, pattern 1111, stream of 10 ones -> det high on bits 4..10; match_count saturates at 3.
6. Assert rst asynchronously mid-clock while in ARMED -> outputs clear immediately and pat_reg = 1011. After release, 0,1,1 produces no det; 1,0,1,1 produces det on its 4th bit.

Source files
------------

// File: rtl/seq_detector_mealy_param_if.sv
// Serial-stream, pattern-load and status signals of the parametrised Mealy sequence detector.
// The master modport drives the stream and the pattern; the slave modport is the detector.
interface seq_detector_mealy_param_if #(
    parameter int unsigned SEQ_LEN = 4,
    parameter int unsigned CNT_W   = 8
);
    logic               in_valid;
    logic               in_bit;
    logic [SEQ_LEN-1:0] pattern;
    logic               pattern_load;
    logic               overlap_en;
    logic               det;
    logic [CNT_W-1:0]   match_count;
    logic [1:0]         state;

    modport master (
        output in_valid, in_bit, pattern, pattern_load, overlap_en,
        input  det, match_count, state
    );

    modport slave (
        input  in_valid, in_bit, pattern, pattern_load, overlap_en,
        output det, match_count, state
    );
endinterface

// File: rtl/seq_detector_mealy_param.sv
// Mealy serial-pattern detector: window compare of the last SEQ_LEN accepted bits against a
// loadable pattern, with overlapping or non-overlapping detection and a saturating match counter.
module seq_detector_mealy_param #(
    parameter int unsigned           SEQ_LEN     = 4,
    parameter logic [SEQ_LEN-1:0]    DEFAULT_PAT = 4'b1011,
    parameter int unsigned           CNT_W       = 8
) (
    input logic                     clk,
    input logic                     rst,
    seq_detector_mealy_param_if.slave bus
);
    localparam int unsigned    FW       = $clog2(SEQ_LEN);
    localparam logic [FW-1:0]  FILL_MAX = FW'(SEQ_LEN - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] ARMED = 2'd2;

    logic [SEQ_LEN-1:0] pat_reg, pat_nxt;
    logic [SEQ_LEN-2:0] hist_q, hist_nxt;
    logic [FW-1:0]      fill_q, fill_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [1:0]         state_q, state_nxt;
    logic [SEQ_LEN-1:0] window;
    logic               det_w;

    // Newest bit sits at the LSB, so the window lines up with pattern[0] as the last bit.
    assign window = {hist_q, bus.in_bit};
    assign det_w  = bus.in_valid & ~bus.pattern_load & ~rst &
                    (state_q == ARMED) & (window == pat_reg);

    always_comb begin
        pat_nxt  = pat_reg;
        hist_nxt = hist_q;
        fill_nxt = fill_q;
        cnt_nxt  = cnt_q;
        if (bus.pattern_load) begin
            pat_nxt  = bus.pattern;
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (bus.in_valid) begin
            if (det_w) begin
                if (cnt_q != '1)
                    cnt_nxt = cnt_q + 1'b1;
                if (bus.overlap_en) begin
                    hist_nxt = window[SEQ_LEN-2:0];
                end else begin
                    hist_nxt = '0;
                    fill_nxt = '0;
                end
            end else begin
                hist_nxt = window[SEQ_LEN-2:0];
                if (fill_q != FILL_MAX)
                    fill_nxt = fill_q + 1'b1;
            end
        end

        if (fill_nxt == '0)
            state_nxt = IDLE;
        else if (fill_nxt == FILL_MAX)
            state_nxt = ARMED;
        else
            state_nxt = FILL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_reg <= DEFAULT_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            pat_reg <= pat_nxt;
            hist_q  <= hist_nxt;
            fill_q  <= fill_nxt;
            cnt_q   <= cnt_nxt;
            state_q <= state_nxt;
        end
    end

    assign bus.det         = det_w;
    assign bus.match_count = cnt_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_seq_detector_mealy_param.sv
// Self-checking bench for seq_detector_mealy_param: table-driven streams plus hand-written
// corner cases (counter saturation with CNT_W=2, asynchronous reset while armed).
module tb_seq_detector_mealy_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0, bt = 1'b0, ld = 1'b0, ov = 1'b1;
    logic [3:0] pt  = 4'b0000;

    always #5 clk = ~clk;

    seq_detector_mealy_param_if #(.SEQ_LEN(4), .CNT_W(8)) bus ();
    seq_detector_mealy_param_if #(.SEQ_LEN(4), .CNT_W(2)) bus2 ();

    assign bus.in_valid      = vld;
    assign bus.in_bit        = bt;
    assign bus.pattern       = pt;
    assign bus.pattern_load  = ld;
    assign bus.overlap_en    = ov;
    assign bus2.in_valid     = vld;
    assign bus2.in_bit       = bt;
    assign bus2.pattern      = pt;
    assign bus2.pattern_load = ld;
    assign bus2.overlap_en   = ov;

    seq_detector_mealy_param #(.SEQ_LEN(4), .DEFAULT_PAT(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    seq_detector_mealy_param #(.SEQ_LEN(4), .DEFAULT_PAT(4'b1011), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    typedef struct {
        logic       rs;
        logic       vld, bt, ld;
        logic [3:0] pat;
        logic       ov;
        logic       edet;
        logic [7:0] ecnt;
        logic [1:0] est;
    } vec_t;

    typedef struct {
        logic       edet;
        logic [7:0] ecnt;
        logic [1:0] est;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic rs, input logic v, input logic b, input logic l,
                       input logic [3:0] p, input logic o, input logic d,
                       input logic [7:0] c, input logic [1:0] s);
        vec_t e;
        e.rs = rs; e.vld = v; e.bt = b; e.ld = l; e.pat = p; e.ov = o;
        e.edet = d; e.ecnt = c; e.est = s;
        tbl.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = 1'b0; ld = 1'b0;
        #1;
        chk("rst_det", {7'd0, bus.det}, 8'd0);
        chk("rst_cnt", bus.match_count, 8'd0);
        chk("rst_state", {6'd0, bus.state}, 8'd0);
        chk("rst_cnt2", {6'd0, bus2.match_count}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 time unit after a rising edge; det is checked at the falling edge,
    // registered outputs 1 time unit after the following rising edge.
    task automatic step(input logic v, input logic b, input logic l, input logic [3:0] p,
                        input logic o, input bit sel, input logic d,
                        input logic [7:0] c, input logic [1:0] s);
        exp_t e;
        vld = v; bt = b; ld = l; pt = p; ov = o;
        e.edet = d; e.ecnt = c; e.est = s;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk(sel ? "det2" : "det", {7'd0, sel ? bus2.det : bus.det}, {7'd0, e.edet});
        @(posedge clk);
        #1;
        chk(sel ? "cnt2" : "cnt", sel ? {6'd0, bus2.match_count} : bus.match_count, e.ecnt);
        chk(sel ? "state2" : "state", {6'd0, sel ? bus2.state : bus.state}, {6'd0, e.est});
    endtask

    initial begin
        // overlapping, default pattern 1011: stream 1011011
        add(1,1,1,0,4'h0,1, 0,0,1); add(0,1,0,0,4'h0,1, 0,0,1);
        add(0,1,1,0,4'h0,1, 0,0,2); add(0,1,1,0,4'h0,1, 1,1,2);
        add(0,1,0,0,4'h0,1, 0,1,2); add(0,1,1,0,4'h0,1, 0,1,2);
        add(0,1,1,0,4'h0,1, 1,2,2);
        // non-overlapping, same stream
        add(1,1,1,0,4'h0,0, 0,0,1); add(0,1,0,0,4'h0,0, 0,0,1);
        add(0,1,1,0,4'h0,0, 0,0,2); add(0,1,1,0,4'h0,0, 1,1,0);
        add(0,1,0,0,4'h0,0, 0,1,1); add(0,1,1,0,4'h0,0, 0,1,1);
        add(0,1,1,0,4'h0,0, 0,1,2);
        // in_valid gap with in_bit toggling
        add(1,1,1,0,4'h0,1, 0,0,1); add(0,1,0,0,4'h0,1, 0,0,1);
        add(0,0,1,0,4'h0,1, 0,0,1); add(0,0,0,0,4'h0,1, 0,0,1);
        add(0,0,1,0,4'h0,1, 0,0,1); add(0,1,1,0,4'h0,1, 0,0,2);
        add(0,1,1,0,4'h0,1, 1,1,2);
        // load 0110 while armed and a would-be matching bit is presented
        add(1,1,1,0,4'h0,1, 0,0,1); add(0,1,0,0,4'h0,1, 0,0,1);
        add(0,1,1,0,4'h0,1, 0,0,2); add(0,1,1,1,4'b0110,1, 0,0,0);
        add(0,1,0,0,4'h0,1, 0,0,1); add(0,1,1,0,4'h0,1, 0,0,1);
        add(0,1,1,0,4'h0,1, 0,0,2); add(0,1,0,0,4'h0,1, 1,1,2);

        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].rs) do_reset();
            step(tbl[i].vld, tbl[i].bt, tbl[i].ld, tbl[i].pat, tbl[i].ov, 1'b0,
                 tbl[i].edet, tbl[i].ecnt, tbl[i].est);
        end

        // CNT_W=2 saturation: pattern 1111, ten ones
        do_reset();
        step(1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
        for (int unsigned i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, (i >= 4),
                 (i >= 4) ? ((i - 3 > 3) ? 8'd3 : 8'(i - 3)) : 8'd0,
                 (i < 3) ? 2'd1 : 2'd2);
        end
        chk("cnt_8bit_nosat", bus.match_count, 8'd7);

        // asynchronous reset mid-cycle while armed and det is high
        vld = 1'b1; bt = 1'b1; ld = 1'b0; ov = 1'b1;
        @(negedge clk);
        chk("pre_rst_det", {7'd0, bus.det}, 8'd1);
        chk("pre_rst_state", {6'd0, bus.state}, 8'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_det", {7'd0, bus.det}, 8'd0);
        chk("async_cnt", bus.match_count, 8'd0);
        chk("async_state", {6'd0, bus.state}, 8'd0);
        vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // pattern must be back to 1011: 0,1,1 no det, then 1,0,1,1 detects on the last bit
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd2);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd2);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd2);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd2);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 8'd1, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
